// File: rtl/if_pc_gen_pkg.sv
// if_pc_gen_pkg: shared constants and encodings for the fetch-address generator
package if_pc_gen_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  typedef enum logic {RUN, DS} fetch_state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_ID, SRC_EX, SRC_REFRESH} redir_src_t;
endpackage

// File: rtl/if_redirect_arb.sv
// if_redirect_arb: priority mux over redirect sources (refresh > ex mispredict > id jr)
module if_redirect_arb
  import if_pc_gen_pkg::*;
(
  input  logic        refresh,
  input  logic [31:0] refresh_target,
  input  logic        ex_bp_fail,
  input  logic [31:0] ex_fix_target,
  input  logic        id_j_r,
  input  logic [31:0] id_jr_target,
  output logic        redir_valid,
  output logic [31:0] redir_target,
  output redir_src_t  redir_src
);
  // pick the highest-priority active redirect
  always_comb begin
    redir_valid  = refresh || ex_bp_fail || id_j_r;
    redir_target = refresh ? refresh_target : ex_bp_fail ? ex_fix_target : id_j_r ? id_jr_target : '0;
    redir_src    = refresh ? SRC_REFRESH : ex_bp_fail ? SRC_EX : id_j_r ? SRC_ID : SRC_NONE;
  end
endmodule

// File: rtl/if_pc_gen.sv
// if_pc_gen: fetch PC register, I-cache request and delay-slot-aware redirects (macro GSHARE_PRED_EN enables gshare direction)
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        refresh,
  input  logic [31:0] refresh_target,
  input  logic        ex_bp_fail,
  input  logic [31:0] ex_fix_target,
  input  logic        id_j_r,
  input  logic [31:0] id_jr_target,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  input  logic        gshare_take,
  input  logic        inst_addr_ok,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  output logic [31:0] if_pc,
  output logic        if_inst_req,
  output logic        if_addr_error,
  output logic        if_btb_hit,
  output logic [31:0] if_btb_target,
  output logic        if_gshare_take
);
  logic [31:0] pc, pc_n, pend_tgt, pend_tgt_n, redir_tgt, redir_target, eff_tgt;
  fetch_state_t state, state_n;
  redir_src_t redir_src, pend_src;
  logic resetn_q, hold, redir_pend, redir_valid;
  logic adv, busy, step, raw_take, take, use_new, eff_valid;

  if_redirect_arb u_arb (
    .refresh        (refresh),
    .refresh_target (refresh_target),
    .ex_bp_fail     (ex_bp_fail),
    .ex_fix_target  (ex_fix_target),
    .id_j_r         (id_j_r),
    .id_jr_target   (id_jr_target),
    .redir_valid    (redir_valid),
    .redir_target   (redir_target),
    .redir_src      (redir_src)
  );

`ifdef GSHARE_PRED_EN
  assign raw_take = btb_hit && gshare_take;
`else
  // static taken-on-hit: gshare_take is a don't-care
  assign raw_take = btb_hit && (gshare_take || 1'b1);
`endif

  assign if_pc          = pc;
  assign inst_addr      = pc;
  assign if_addr_error  = |pc[1:0];
  assign inst_req       = resetn_q && !if_addr_error && (!stall || hold);
  assign adv            = inst_req && inst_addr_ok;
  assign busy           = inst_req && !inst_addr_ok;
  assign step           = adv || (if_addr_error && !stall);
  assign take           = (state == RUN) && raw_take;
  assign if_gshare_take = take;
  assign if_btb_hit     = btb_hit;
  assign if_btb_target  = btb_target;
  assign if_inst_req    = adv && !redir_pend;
  assign use_new        = redir_valid && (!redir_pend || redir_src >= pend_src);
  assign eff_valid      = use_new || redir_pend;
  assign eff_tgt        = use_new ? redir_target : redir_tgt;

  // next PC: redirect beats the delay-slot FSM; nothing moves while a request waits
  always_comb begin
    pc_n       = pc;
    state_n    = state;
    pend_tgt_n = pend_tgt;
    if (!busy && eff_valid) begin
      pc_n       = eff_tgt;
      state_n    = RUN;
      pend_tgt_n = '0;
    end else if (step) begin
      pc_n       = (state == DS) ? pend_tgt : pc + 32'd4;
      state_n    = take ? DS : RUN;
      pend_tgt_n = take ? btb_target : pend_tgt;
    end
  end

  // state registers; redirects during an unaccepted request are parked until accept
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc         <= RESET_PC;
      state      <= RUN;
      pend_tgt   <= '0;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
      pend_src   <= SRC_NONE;
      hold       <= 1'b0;
      resetn_q   <= 1'b0;
    end else begin
      pc       <= pc_n;
      state    <= state_n;
      pend_tgt <= pend_tgt_n;
      hold     <= busy;
      resetn_q <= 1'b1;
      if (busy && use_new) begin
        redir_pend <= 1'b1;
        redir_tgt  <= redir_target;
        pend_src   <= redir_src;
      end else if (!busy) begin
        redir_pend <= 1'b0;
        pend_src   <= SRC_NONE;
      end
    end
  end
endmodule

// File: tb/tb_if_pc_gen.sv
// tb_if_pc_gen: directed stimulus with a queue-based fetch model and literal spot checks
module tb_if_pc_gen;
  logic clk = 0, resetn = 0, stall = 0, refresh = 0, ex_bp_fail = 0, id_j_r = 0;
  logic btb_hit = 0, gshare_take = 0, inst_addr_ok = 1;
  logic [31:0] refresh_target = 0, ex_fix_target = 0, id_jr_target = 0, btb_target = 0;
  logic inst_req, if_inst_req, if_addr_error, if_btb_hit, if_gshare_take;
  logic [31:0] inst_addr, if_pc, if_btb_target;
  int passed = 0, total = 0;

`ifdef GSHARE_PRED_EN
  localparam logic [31:0] BR_NEXT = 32'h8000_0108;
  localparam logic        GS_NOT  = 1'b0;
`else
  localparam logic [31:0] BR_NEXT = 32'h8000_9000;
  localparam logic        GS_NOT  = 1'b1;
`endif

  if_pc_gen dut (
    .clk(clk), .resetn(resetn), .stall(stall), .refresh(refresh), .refresh_target(refresh_target),
    .ex_bp_fail(ex_bp_fail), .ex_fix_target(ex_fix_target), .id_j_r(id_j_r), .id_jr_target(id_jr_target),
    .btb_hit(btb_hit), .btb_target(btb_target), .gshare_take(gshare_take), .inst_addr_ok(inst_addr_ok),
    .inst_req(inst_req), .inst_addr(inst_addr), .if_pc(if_pc), .if_inst_req(if_inst_req),
    .if_addr_error(if_addr_error), .if_btb_hit(if_btb_hit), .if_btb_target(if_btb_target),
    .if_gshare_take(if_gshare_take)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // model state as it stands after the most recent rising edge
  logic [31:0] m_pc = 32'hBFC0_0000;
  bit m_live = 0, m_hold = 0;
  logic [31:0] m_slot[$];
  int m_rrank[$];
  logic [31:0] m_rtgt[$];

  function automatic bit e_err();
    return m_pc[1:0] != 2'b00;
  endfunction
  function automatic bit e_req();
    return m_live && !e_err() && (!stall || m_hold);
  endfunction
  function automatic bit e_take();
`ifdef GSHARE_PRED_EN
    return m_slot.size() == 0 && btb_hit && gshare_take;
`else
    return m_slot.size() == 0 && btb_hit;
`endif
  endfunction

  initial begin : model_loop
    bit req, adv, busy, tk, newer;
    int cr;
    logic [31:0] ct;
    forever begin
      @(negedge clk);
      #2;
      req = e_req();
      adv = req && inst_addr_ok;
      busy = req && !inst_addr_ok;
      tk = e_take();
      chk("m_inst_req", inst_req, req);
      chk("m_inst_addr", inst_addr, m_pc);
      chk("m_if_pc", if_pc, m_pc);
      chk("m_if_inst_req", if_inst_req, adv && m_rtgt.size() == 0);
      chk("m_addr_error", if_addr_error, e_err());
      chk("m_gshare_take", if_gshare_take, tk);
      chk("m_btb", {if_btb_hit, if_btb_target[30:0]}, {btb_hit, btb_target[30:0]});
      cr = refresh ? 3 : ex_bp_fail ? 2 : id_j_r ? 1 : 0;
      ct = refresh ? refresh_target : ex_bp_fail ? ex_fix_target : id_jr_target;
      if (!resetn) begin
        m_pc = 32'hBFC0_0000;
        m_live = 0;
        m_hold = 0;
        m_slot.delete();
        m_rrank.delete();
        m_rtgt.delete();
      end else begin
        newer = cr > 0 && (m_rrank.size() == 0 || cr >= m_rrank[0]);
        if (busy) begin
          if (newer) begin
            m_rrank = '{cr};
            m_rtgt = '{ct};
          end
        end else begin
          if (newer || m_rtgt.size() > 0) begin
            m_pc = newer ? ct : m_rtgt[0];
            m_slot.delete();
          end else if (adv || (e_err() && !stall)) begin
            if (m_slot.size() > 0) m_pc = m_slot.pop_front();
            else begin
              if (tk) m_slot.push_back(btb_target);
              m_pc = m_pc + 32'd4;
            end
          end
          m_rrank.delete();
          m_rtgt.delete();
        end
        m_hold = busy;
        m_live = 1;
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    refresh = 0; ex_bp_fail = 0; id_j_r = 0; btb_hit = 0; gshare_take = 0; stall = 0; inst_addr_ok = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nxt(); #1 chk("rst_req", inst_req, 0); chk("rst_pc", if_pc, 32'hBFC0_0000);
    nxt(); resetn = 1; #1 chk("rel_req", inst_req, 0);
    nxt(); #1 chk("seq0", inst_addr, 32'hBFC0_0000); chk("seq0_ireq", if_inst_req, 1);
    nxt(); #1 chk("seq1", inst_addr, 32'hBFC0_0004);
    nxt(); #1 chk("seq2", inst_addr, 32'hBFC0_0008);
    nxt();
    nxt(); btb_hit = 1; btb_target = 32'h8000_1000; gshare_take = 1;
    #1 chk("br_pc", inst_addr, 32'hBFC0_0010); chk("br_take", if_gshare_take, 1);
    nxt(); #1 chk("br_ds", inst_addr, 32'hBFC0_0014);
    nxt(); #1 chk("br_tgt", inst_addr, 32'h8000_1000);
    nxt(); refresh = 1; refresh_target = 32'hBFC0_0380; ex_bp_fail = 1; ex_fix_target = 32'h8000_2000;
    nxt(); #1 chk("prio_refresh", if_pc, 32'hBFC0_0380);
    nxt(); inst_addr_ok = 0; id_j_r = 1; id_jr_target = 32'h8000_3000;
    #1 chk("hold0", inst_addr, 32'hBFC0_0384);
    nxt(); inst_addr_ok = 0; stall = 1; #1 chk("hold_stall_req", inst_req, 1); chk("hold1", inst_addr, 32'hBFC0_0384);
    nxt(); inst_addr_ok = 0; #1 chk("hold2", inst_addr, 32'hBFC0_0384);
    nxt(); #1 chk("wrongpath_ireq", if_inst_req, 0); chk("accept_req", inst_req, 1);
    nxt(); #1 chk("jr_tgt", inst_addr, 32'h8000_3000);
    nxt(); inst_addr_ok = 0; ex_bp_fail = 1; ex_fix_target = 32'h8000_4000;
    nxt(); inst_addr_ok = 0; id_j_r = 1; id_jr_target = 32'h8000_5000;
    nxt(); #1 chk("pend_ireq", if_inst_req, 0);
    nxt(); #1 chk("pend_keep_high", inst_addr, 32'h8000_4000);
    nxt(); refresh = 1; refresh_target = 32'h8000_0002;
    nxt(); #1 chk("aerr", if_addr_error, 1); chk("aerr_req", inst_req, 0);
    chk("aerr_ireq", if_inst_req, 0); chk("aerr_pc", if_pc, 32'h8000_0002);
    nxt(); #1 chk("aerr_adv", if_pc, 32'h8000_0006); refresh = 1; refresh_target = 32'h8000_0100;
    nxt(); btb_hit = 1; btb_target = 32'h8000_9000; gshare_take = 0;
    #1 chk("gs_pc", if_pc, 32'h8000_0100); chk("gs_noerr", if_addr_error, 0); chk("gs_take", if_gshare_take, GS_NOT);
    nxt();
    nxt(); #1 chk("gs_next", if_pc, BR_NEXT);
    nxt(); stall = 1; #1 chk("stall_req", inst_req, 0); chk("stall_pc0", if_pc, BR_NEXT + 32'd4);
    nxt(); stall = 1; #1 chk("stall_pc1", if_pc, BR_NEXT + 32'd4);
    nxt(); #1 chk("unstall_req", inst_req, 1); refresh = 1; refresh_target = 32'hFFFF_FFFC;
    nxt(); #1 chk("wrap0", if_pc, 32'hFFFF_FFFC);
    nxt(); #1 chk("wrap1", if_pc, 32'h0000_0000);
    nxt(); btb_hit = 1; btb_target = 32'h8000_1000; gshare_take = 1;
    nxt(); btb_hit = 1; btb_target = 32'h8000_7000; gshare_take = 1;
    #1 chk("ds_ignore", if_gshare_take, 0);
    nxt(); #1 chk("ds_tgt", if_pc, 32'h8000_1000);
    nxt(); inst_addr_ok = 0;
    nxt(); inst_addr_ok = 0; resetn = 0; #1 chk("rst_mid_req", inst_req, 1);
    nxt(); resetn = 1; #1 chk("rst_mid_pc", if_pc, 32'hBFC0_0000); chk("rst_mid_noreq", inst_req, 0);
    nxt(); #1 chk("rst_restart", inst_addr, 32'hBFC0_0000); chk("rst_restart_req", inst_req, 1);
    nxt();
    nxt();
    #3;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
